smc_ctrl: RTL

SMC_CTRL -- requirements
Module: smc_ctrl

---
 rtl/smc_pkg.sv | 19 +
 rtl/smc_calc_lane.sv | 34 +++
 rtl/smc_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/smc_pkg.sv
// Shared constants and state encoding for the smc_ctrl MOSFET-evaluation controller.
package smc_pkg;

  localparam int unsigned MOS_NUM = 6;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned W_A     = 3;
  localparam int unsigned W_B     = 4;
  localparam int unsigned W_C     = 5;
  localparam int unsigned IN_W    = 3;
  localparam int unsigned LANE_W  = 7;
  localparam int unsigned CALC_W  = 10;
  localparam int unsigned SUM_W   = 12;
  localparam int unsigned OUT_W   = 10;
  localparam int unsigned BEAT_W  = 3;
  localparam int unsigned GAP_W   = 5;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

endpackage

// File: rtl/smc_calc_lane.sv
// Combinational single-MOSFET evaluator: Id or gm from vgs/vds/w (square-law, /3 scaled).
module smc_calc_lane
  import smc_pkg::*;
(
  input  logic [IN_W-1:0]   vgs,
  input  logic [IN_W-1:0]   vds,
  input  logic [IN_W-1:0]   w,
  input  logic              sel_id,
  output logic [LANE_W-1:0] res_c
);

  logic [CALC_W-1:0] ov, vd, wd, id_v, gm_v;

  always_comb begin
    ov   = CALC_W'(vgs) - CALC_W'(1);
    vd   = CALC_W'(vds);
    wd   = CALC_W'(w);
    id_v = '0;
    gm_v = '0;
    if (vgs == '0) begin
      id_v = '0;
      gm_v = '0;
    end else if (ov > vd) begin
      // triode: 2*ov*vds - vds^2 is non-negative because ov > vds
      id_v = (wd * (CALC_W'(2) * ov * vd - vd * vd)) / CALC_W'(3);
      gm_v = (CALC_W'(2) * wd * vd) / CALC_W'(3);
    end else begin
      id_v = (wd * ov * ov) / CALC_W'(3);
      gm_v = (CALC_W'(2) * wd * ov) / CALC_W'(3);
    end
    res_c = sel_id ? LANE_W'(id_v) : LANE_W'(gm_v);
  end

endmodule

// File: rtl/smc_ctrl.sv
// Six-beat MOSFET frame controller: keeps the best three lane results and emits a weighted result.
// Optional SMC_CTRL_TIMEOUT_EN aborts a stalled frame after TIMEOUT gap cycles and pulses err.
module smc_ctrl
  import smc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  vgs,
  input  logic [IN_W-1:0]  vds,
  input  logic [IN_W-1:0]  w,
  input  logic [1:0]       mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             err
);

  state_t              state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [1:0]          mode_q;
  logic [LANE_W-1:0]   lane_q, lane_c;
  logic                lane_vld;
  logic [LANE_W-1:0]   k0, k1, k2, k0_n, k1_n, k2_n;
  logic [1:0]          fill;
  logic                accept, sel_id;
  logic [2:0]          better;
  logic [LANE_W-1:0]   ra, rb, rc;
  logic [SUM_W-1:0]    wsum;
  logic [OUT_W-1:0]    result;

  assign accept = in_valid & in_ready;
  // beat 0 evaluates with the live mode; later beats use the frame's captured mode
  assign sel_id = (state == IDLE) ? mode[0] : mode_q[0];

  smc_calc_lane u_lane (
    .vgs    (vgs),
    .vds    (vds),
    .w      (w),
    .sel_id (sel_id),
    .res_c  (lane_c)
  );

  // Sorted insert; k0 is the best entry, empty slots always accept, ties keep older entries first
  always_comb begin
    better[0] = (fill == 2'd0) | (mode_q[1] ? (lane_q > k0) : (lane_q < k0));
    better[1] = (fill <= 2'd1) | (mode_q[1] ? (lane_q > k1) : (lane_q < k1));
    better[2] = (fill <= 2'd2) | (mode_q[1] ? (lane_q > k2) : (lane_q < k2));
    k0_n = k0;
    k1_n = k1;
    k2_n = k2;
    if (better[0]) begin
      k0_n = lane_q;
      k1_n = k0;
      k2_n = k1;
    end else if (better[1]) begin
      k1_n = lane_q;
      k2_n = k1;
    end else if (better[2]) begin
      k2_n = lane_q;
    end
  end

  // a >= b >= c for largest, c <= b <= a for smallest
  always_comb begin
    ra = mode_q[1] ? k0 : k2;
    rb = k1;
    rc = mode_q[1] ? k2 : k0;
    wsum = SUM_W'(W_A * ra + W_B * rb + W_C * rc);
    if (mode_q[0]) result = OUT_W'(wsum / SUM_W'(W_A + W_B + W_C));
    else           result = OUT_W'(SUM_W'(ra) + SUM_W'(rb) + SUM_W'(rc));
  end

`ifdef SMC_CTRL_TIMEOUT_EN
  logic [GAP_W-1:0] gap_cnt;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      beat_cnt  <= '0;
      mode_q    <= '0;
      lane_q    <= '0;
      lane_vld  <= 1'b0;
      k0        <= '0;
      k1        <= '0;
      k2        <= '0;
      fill      <= '0;
`ifdef SMC_CTRL_TIMEOUT_EN
      gap_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef SMC_CTRL_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      lane_vld  <= accept;
      if (accept) lane_q <= lane_c;

      if (accept && state == IDLE) begin
        k0     <= '0;
        k1     <= '0;
        k2     <= '0;
        fill   <= '0;
        mode_q <= mode;
      end else if (lane_vld) begin
        k0   <= k0_n;
        k1   <= k1_n;
        k2   <= k2_n;
        fill <= (fill == 2'd3) ? fill : fill + 2'd1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state    <= LOAD;
            beat_cnt <= BEAT_W'(1);
`ifdef SMC_CTRL_TIMEOUT_EN
            gap_cnt  <= '0;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
`ifdef SMC_CTRL_TIMEOUT_EN
            gap_cnt <= '0;
`endif
            if (beat_cnt == BEAT_W'(MOS_NUM - 1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
`ifdef SMC_CTRL_TIMEOUT_EN
          else if (gap_cnt == GAP_W'(TIMEOUT - 1)) begin
            state    <= IDLE;
            err_q    <= 1'b1;
            beat_cnt <= '0;
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
`endif
        end
        DRAIN: begin
          if (beat_cnt == BEAT_W'(1)) begin
            state    <= OUT;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        OUT: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b1;
          out_data  <= result;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
